// File: rtl/taxi_eth_rate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : taxi_eth_rate_pkg                                            |
// | Description : Shared speed encoding and divider helpers for the GMII       |
// |               rate adapter.                                                |
// |   speed_t    : 0=10M, 1=100M, 2=1000M, 3=reserved                          |
// |   rate_div   : byte replication factor N for a speed (7 bits)             |
// |   speed_norm : maps a raw 2-bit request onto an applied speed             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package taxi_eth_rate_pkg;

    localparam int DIV_W = 7;

    typedef enum logic [1:0] {
        SPEED_10   = 2'd0,
        SPEED_100  = 2'd1,
        SPEED_1000 = 2'd2,
        SPEED_RSVD = 2'd3
    } speed_t;

    function automatic logic [DIV_W-1:0] rate_div(input speed_t speed);
        logic [DIV_W-1:0] n;
        n = 7'd1;
        case (speed)
            SPEED_10:  n = 7'd100;
            SPEED_100: n = 7'd10;
            default:   n = 7'd1;
        endcase
        return n;
    endfunction

    // The reserved code runs as gigabit, so the applied speed never reports it.
    function automatic speed_t speed_norm(input logic [1:0] code);
        speed_t s;
        s = (code == 2'd3) ? SPEED_1000 : speed_t'(code);
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/taxi_eth_gmii_rate_adapt_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : taxi_eth_gmii_rate_adapt_ch                                  |
// | Description : One channel of the GMII rate adapter. TX replicates each MAC |
// |               byte N times, RX aligns on frame start and decimates the     |
// |               replicated stream back to one byte per clock enable.         |
// | Ports       : clk, rst_n (async, active low)                               |
// |               cfg_speed / link_speed   requested / applied speed           |
// |               mac_tx*  -> phy_tx*      TX replicate, tx_clk_enable         |
// |               phy_rx*  -> mac_rx*      RX decimate, rx_clk_enable          |
// |               stat_rx_align_err        frame ended mid replication group   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module taxi_eth_gmii_rate_adapt_ch
    import taxi_eth_rate_pkg::*;
#(
    parameter bit RX_ALIGN_CHECK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] cfg_speed,
    output logic [1:0] link_speed,
    input  logic [7:0] mac_txd,
    input  logic       mac_tx_en,
    input  logic       mac_tx_er,
    output logic       tx_clk_enable,
    output logic [7:0] phy_txd,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    input  logic [7:0] phy_rxd,
    input  logic       phy_rx_dv,
    input  logic       phy_rx_er,
    output logic       rx_clk_enable,
    output logic [7:0] mac_rxd,
    output logic       mac_rx_dv,
    output logic       mac_rx_er,
    output logic       stat_rx_align_err
);

    speed_t             r_tx_speed;
    speed_t             r_rx_speed;
    logic [DIV_W-1:0]   r_tx_cnt;
    logic [DIV_W-1:0]   r_rx_cnt;
    logic               r_tx_clk_en;
    logic [7:0]         r_phy_txd;
    logic               r_phy_tx_en;
    logic               r_phy_tx_er;
    logic               r_rx_dv_prev;
    logic               r_rx_clk_en;
    logic [7:0]         r_mac_rxd;
    logic               r_mac_rx_dv;
    logic               r_mac_rx_er;
    logic               r_align_err;

    logic [DIV_W-1:0]   w_tx_n;
    logic [DIV_W-1:0]   w_rx_n;
    logic               w_tx_bnd;
    logic               w_tx_apply;
    logic [DIV_W-1:0]   w_tx_cnt_nxt;
    logic               w_rx_bnd;
    logic               w_rx_rise;
    logic               w_rx_fall;
    logic               w_rx_apply;
    logic               w_rx_sample;
    logic [DIV_W-1:0]   w_rx_cnt_nxt;

    always_comb begin
        w_tx_n       = rate_div(r_tx_speed);
        w_tx_bnd     = (r_tx_cnt == w_tx_n - DIV_W'(1));
        // Speed only moves between frames, at a group boundary, so no byte
        // is ever cut short and phy_tx_en cannot glitch.
        w_tx_apply   = w_tx_bnd && !mac_tx_en && !r_phy_tx_en;
        w_tx_cnt_nxt = w_tx_bnd ? '0 : r_tx_cnt + DIV_W'(1);

        w_rx_n       = rate_div(r_rx_speed);
        w_rx_bnd     = (r_rx_cnt == w_rx_n - DIV_W'(1));
        w_rx_rise    = phy_rx_dv && !r_rx_dv_prev;
        w_rx_fall    = !phy_rx_dv && r_rx_dv_prev;
        // RX follows the applied TX speed, but only while fully idle.
        w_rx_apply   = w_rx_bnd && !phy_rx_dv && !r_mac_rx_dv &&
                       (r_rx_speed != r_tx_speed);
        // Frame start re-phases the decimator: the rising cycle is the first
        // sample of its group, so the counter continues from 1.
        w_rx_sample  = (r_rx_cnt == '0) || w_rx_rise;
        if (w_rx_rise) begin
            w_rx_cnt_nxt = (w_rx_n == DIV_W'(1)) ? '0 : DIV_W'(1);
        end else if (w_rx_bnd) begin
            w_rx_cnt_nxt = '0;
        end else begin
            w_rx_cnt_nxt = r_rx_cnt + DIV_W'(1);
        end
    end

    // TX: divider, clock enable, replicate register and speed latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_speed  <= SPEED_1000;
            r_tx_cnt    <= '0;
            r_tx_clk_en <= 1'b0;
            r_phy_txd   <= '0;
            r_phy_tx_en <= 1'b0;
            r_phy_tx_er <= 1'b0;
        end else begin
            if (w_tx_apply) begin
                r_tx_speed <= speed_norm(cfg_speed);
            end
            r_tx_cnt    <= w_tx_cnt_nxt;
            // Registered copy of (counter == 0) for the upcoming cycle.
            r_tx_clk_en <= (w_tx_cnt_nxt == '0);
            if (r_tx_clk_en) begin
                r_phy_txd   <= mac_txd;
                r_phy_tx_en <= mac_tx_en;
                r_phy_tx_er <= mac_tx_er;
            end
        end
    end

    // RX: alignment, decimation and alignment-error detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_speed   <= SPEED_1000;
            r_rx_cnt     <= '0;
            r_rx_dv_prev <= 1'b0;
            r_rx_clk_en  <= 1'b0;
            r_mac_rxd    <= '0;
            r_mac_rx_dv  <= 1'b0;
            r_mac_rx_er  <= 1'b0;
            r_align_err  <= 1'b0;
        end else begin
            if (w_rx_apply) begin
                r_rx_speed <= r_tx_speed;
            end
            r_rx_cnt     <= w_rx_cnt_nxt;
            r_rx_dv_prev <= phy_rx_dv;
            r_rx_clk_en  <= w_rx_sample;
            // Error is taken from the sampled cycle only, not OR-ed over the group.
            if (w_rx_sample) begin
                r_mac_rxd   <= phy_rxd;
                r_mac_rx_dv <= phy_rx_dv;
                r_mac_rx_er <= phy_rx_er;
            end
            r_align_err  <= RX_ALIGN_CHECK && w_rx_fall && (r_rx_cnt != '0);
        end
    end

    assign link_speed        = r_tx_speed;
    assign tx_clk_enable     = r_tx_clk_en;
    assign phy_txd           = r_phy_txd;
    assign phy_tx_en         = r_phy_tx_en;
    assign phy_tx_er         = r_phy_tx_er;
    assign rx_clk_enable     = r_rx_clk_en;
    assign mac_rxd           = r_mac_rxd;
    assign mac_rx_dv         = r_mac_rx_dv;
    assign mac_rx_er         = r_mac_rx_er;
    assign stat_rx_align_err = r_align_err;

endmodule
`default_nettype wire

// File: rtl/taxi_eth_gmii_rate_adapt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : taxi_eth_gmii_rate_adapt                                     |
// | Description : Multi-channel GMII rate adapter between 1G MAC cores running |
// |               with clk_enable and a shared SGMII/QSGMII PCS. Channels are  |
// |               fully independent; this level only slices the buses.         |
// | Ports       : clk, rst_n; per channel (CH wide, x8 for data, x2 speed):    |
// |               cfg_speed, link_speed, mac_tx*, tx_clk_enable, phy_tx*,      |
// |               phy_rx*, rx_clk_enable, mac_rx*, stat_rx_align_err           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module taxi_eth_gmii_rate_adapt
    import taxi_eth_rate_pkg::*;
#(
    parameter int CH             = 4,
    parameter bit RX_ALIGN_CHECK = 1'b1
) (
    input  logic [0:0]      clk,
    input  logic            rst_n,
    input  logic [2*CH-1:0] cfg_speed,
    output logic [2*CH-1:0] link_speed,
    input  logic [8*CH-1:0] mac_txd,
    input  logic [CH-1:0]   mac_tx_en,
    input  logic [CH-1:0]   mac_tx_er,
    output logic [CH-1:0]   tx_clk_enable,
    output logic [8*CH-1:0] phy_txd,
    output logic [CH-1:0]   phy_tx_en,
    output logic [CH-1:0]   phy_tx_er,
    input  logic [8*CH-1:0] phy_rxd,
    input  logic [CH-1:0]   phy_rx_dv,
    input  logic [CH-1:0]   phy_rx_er,
    output logic [CH-1:0]   rx_clk_enable,
    output logic [8*CH-1:0] mac_rxd,
    output logic [CH-1:0]   mac_rx_dv,
    output logic [CH-1:0]   mac_rx_er,
    output logic [CH-1:0]   stat_rx_align_err
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        taxi_eth_gmii_rate_adapt_ch #(
            .RX_ALIGN_CHECK(RX_ALIGN_CHECK)
        ) u_ch (
            .clk              (clk),
            .rst_n            (rst_n),
            .cfg_speed        (cfg_speed[2*g +: 2]),
            .link_speed       (link_speed[2*g +: 2]),
            .mac_txd          (mac_txd[8*g +: 8]),
            .mac_tx_en        (mac_tx_en[g]),
            .mac_tx_er        (mac_tx_er[g]),
            .tx_clk_enable    (tx_clk_enable[g]),
            .phy_txd          (phy_txd[8*g +: 8]),
            .phy_tx_en        (phy_tx_en[g]),
            .phy_tx_er        (phy_tx_er[g]),
            .phy_rxd          (phy_rxd[8*g +: 8]),
            .phy_rx_dv        (phy_rx_dv[g]),
            .phy_rx_er        (phy_rx_er[g]),
            .rx_clk_enable    (rx_clk_enable[g]),
            .mac_rxd          (mac_rxd[8*g +: 8]),
            .mac_rx_dv        (mac_rx_dv[g]),
            .mac_rx_er        (mac_rx_er[g]),
            .stat_rx_align_err(stat_rx_align_err[g])
        );
    end

endmodule
`default_nettype wire
